// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of mask searching ptr, ptr+1, ... mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold, bounded tenure and registered one-hot grant.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state, state_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [IDX_W-1:0] ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign others    = req & ~(N_REQ'(1) << owner);
    assign pick_mask = (state == IDLE) ? req : others;

    rr_pick4 u_pick (
        .mask  (pick_mask),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = GRANT;
                    owner_nx = pick_idx;
                    cnt_nx   = CNT_W'(1);
                    ptr_nx   = pick_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    if (pick_found) begin
                        owner_nx = pick_idx;
                        cnt_nx   = CNT_W'(1);
                        ptr_nx   = pick_idx + IDX_W'(1);
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (cnt == HOLD_LIM && pick_found) begin
                    // Tenure used up while someone waits: preempt.
                    owner_nx = pick_idx;
                    cnt_nx   = CNT_W'(1);
                    ptr_nx   = pick_idx + IDX_W'(1);
                end else if (cnt != HOLD_LIM) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state so gnt changes cleanly at a single edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= (state_nx == GRANT) ? (N_REQ'(1) << owner_nx) : '0;
            gnt_id    <= (state_nx == GRANT) ? owner_nx : '0;
            gnt_valid <= (state_nx == GRANT);
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized bench for rr_arbiter4 with MAX_HOLD=4 and MAX_HOLD=1 instances.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt4, gnt1;
    logic [1:0] gnt_id4, gnt_id1;
    logic       gnt_valid4, gnt_valid1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int owner;  // -1 means nobody holds the grant
        int ptr;
        int hold;
    } mstate_t;

    mstate_t m4, m1;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt4),
        .gnt_id    (gnt_id4),
        .gnt_valid (gnt_valid4)
    );

    rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt1),
        .gnt_id    (gnt_id1),
        .gnt_valid (gnt_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mpick(logic [3:0] m, int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [3:0] r, logic rn, int maxh);
        mstate_t n;
        logic [3:0] oth;
        int p;
        n = s;
        if (!rn) begin
            n.owner = -1; n.ptr = 0; n.hold = 0;
        end else if (s.owner < 0) begin
            p = mpick(r, s.ptr);
            if (p >= 0) begin
                n.owner = p; n.hold = 1; n.ptr = (p + 1) % 4;
            end
        end else begin
            oth = r;
            oth[s.owner] = 1'b0;
            p = mpick(oth, s.ptr);
            if (!r[s.owner] || (s.hold >= maxh && p >= 0)) begin
                if (p >= 0) begin
                    n.owner = p; n.hold = 1; n.ptr = (p + 1) % 4;
                end else begin
                    n.owner = -1; n.hold = 0;
                end
            end else begin
                n.hold = (s.hold + 1 > maxh) ? maxh : s.hold + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_gnt(mstate_t s);
        logic [3:0] g;
        g = 4'b0000;
        if (s.owner >= 0) g[s.owner] = 1'b1;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_models();
        chk("h4_gnt", 32'(gnt4), 32'(exp_gnt(m4)));
        chk("h4_id", 32'(gnt_id4), (m4.owner < 0) ? 32'd0 : 32'(m4.owner));
        chk("h4_valid", 32'(gnt_valid4), 32'(m4.owner >= 0));
        chk("h4_onehot", 32'($countones(gnt4) <= 1), 32'd1);
        chk("h1_gnt", 32'(gnt1), 32'(exp_gnt(m1)));
        chk("h1_id", 32'(gnt_id1), (m1.owner < 0) ? 32'd0 : 32'(m1.owner));
        chk("h1_valid", 32'(gnt_valid1), 32'(m1.owner >= 0));
    endtask

    // One clock: drive at negedge, advance models for the next rising edge, sample after it.
    task automatic cyc(input logic [3:0] r, input logic rn);
        @(negedge clk);
        req   = r;
        reset = rn;
        m4 = mstep(m4, r, rn, 4);
        m1 = mstep(m1, r, rn, 1);
        @(posedge clk);
        #1;
        check_models();
    endtask

    initial begin
        logic [3:0] rr;
        logic       rn;
        req   = 4'b0000;
        reset = 1'b0;
        m4 = '{owner: -1, ptr: 0, hold: 0};
        m1 = '{owner: -1, ptr: 0, hold: 0};

        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("reset_gnt", 32'(gnt4), 32'h0);
        chk("reset_id", 32'(gnt_id4), 32'h0);
        chk("reset_valid", 32'(gnt_valid4), 32'h0);

        cyc(4'b0001, 1'b1);
        chk("single_gnt", 32'(gnt4), 32'h1);
        chk("single_id", 32'(gnt_id4), 32'h0);
        chk("single_valid", 32'(gnt_valid4), 32'h1);
        cyc(4'b0000, 1'b1);
        chk("single_rel_gnt", 32'(gnt4), 32'h0);
        chk("single_rel_valid", 32'(gnt_valid4), 32'h0);

        // ptr is 1 here; re-seat it to 0 so the contention sequence starts at master 0.
        cyc(4'b0000, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc(4'b1111, 1'b1);
            chk("contention_gnt", 32'(gnt4), 32'(4'b0001 << ((i / 4) % 4)));
        end
        cyc(4'b0000, 1'b1);

        for (int i = 0; i < 10; i++) begin
            cyc(4'b0100, 1'b1);
            chk("solo_hold_gnt", 32'(gnt4), 32'h4);
        end

        cyc(4'b0000, 1'b1);
        cyc(4'b0001, 1'b1);
        cyc(4'b0111, 1'b1);
        chk("handoff_pre", 32'(gnt4), 32'h1);
        cyc(4'b0110, 1'b1);
        chk("handoff_gnt", 32'(gnt4), 32'h2);
        cyc(4'b0100, 1'b1);
        chk("handoff_to2", 32'(gnt4), 32'h4);
        cyc(4'b0000, 1'b1);
        chk("idle_after2", 32'(gnt4), 32'h0);
        cyc(4'b0101, 1'b1);
        chk("wrap_search_gnt", 32'(gnt4), 32'h1);

        cyc(4'b1000, 1'b1);
        chk("owner3_gnt", 32'(gnt4), 32'h8);
        cyc(4'b1000, 1'b0);
        chk("midreset_gnt", 32'(gnt4), 32'h0);
        chk("midreset_valid", 32'(gnt_valid4), 32'h0);
        cyc(4'b1001, 1'b1);
        chk("post_reset_ptr0", 32'(gnt4), 32'h1);

        cyc(4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0011, 1'b1);
            chk("hold1_alt", 32'(gnt1), 32'((i % 2 == 0) ? 4'b0001 : 4'b0010));
        end

        for (int i = 0; i < 600; i++) begin
            rr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 4'b1111;
            rn = ($urandom_range(0, 39) != 0);
            cyc(rr, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with grant hold and bounded tenure. It generalizes the two-requester priority arbiter so that four masters can share a single resource, such as a bus port or memory bank. Requests are arbitrated fairly, and the owner keeps the grant while its request stays high. An owner that has held the grant for MAX_HOLD cycles is preempted if another requester is waiting. Grants are registered: one-hot and glitch-free.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles while others wait; legal range 1..255.
- CNT_W, 8: tenure counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- req  in  4  request per master; level-sensitive, bit i = master i.
- gnt  out  4  one-hot grant, registered; all zeros when no owner.
- gnt_id  out  2  index of current owner; 0 when gnt_valid=0.
- gnt_valid  out  1  high when some gnt bit is set; equals |gnt.

## Operation
- Two states: IDLE (no owner) and GRANT (owner held in a 2-bit register).
- Round-robin pointer ptr (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- Pick function: given a 4-bit candidate mask and ptr, it returns the first set bit in search order, plus a found flag.
- IDLE:
  - If req != 0, pick from req. Go to GRANT with owner = pick, cnt = 1, ptr = pick+1.
  - Otherwise stay in IDLE.
- GRANT, with others = req with bit[owner] cleared:
  - req[owner]=0 and others != 0: hand off directly to pick(others). cnt=1, ptr=pick+1.
  - req[owner]=0 and others == 0: go to IDLE. ptr keeps its value (owner+1).
  - req[owner]=1, cnt == MAX_HOLD, others != 0: preempt. Grant goes to pick(others), cnt=1, ptr=pick+1.
  - req[owner]=1 otherwise: keep the owner. cnt increments and saturates at MAX_HOLD.
- Because ptr is always owner+1, the previous owner is never picked when others are waiting.
- Reset (reset=0 sampled at an edge): state=IDLE, ptr=0, cnt=0, gnt=0000, gnt_id=0, gnt_valid=0. Reset wins over every other condition, including mid-grant.
- gnt never has more than one bit set. A handoff changes the grant from one bit to another at a single edge, with no zero cycle between.

## Timing
- Grant latency: req sampled at edge n gives gnt valid after edge n, so one cycle.
- Release latency: req[owner] sampled low at edge n clears or moves gnt at edge n.
- Tenure: under contention, an owner holds gnt for exactly MAX_HOLD consecutive cycles.
  - Preemption happens at the edge where cnt == MAX_HOLD is sampled.
  - A preempted master that keeps requesting is re-granted within 3*MAX_HOLD+1 cycles of losing the grant.
- MAX_HOLD=1: the grant rotates every cycle among all active requesters.
- All outputs come directly from flops. There is no combinational path from req to gnt.

## Structure
- Package arb_pkg holds:
  - typedef for the state enum (IDLE=1'b0, GRANT=1'b1);
  - localparam N_REQ=4;
  - localparam IDX_W=2.
- Sub-module rr_pick4 is purely combinational. Inputs: mask[3:0], ptr[1:0]. Outputs: found, idx[1:0].
  - It is used once in the arbiter, with a muxed mask: req in IDLE, others in GRANT.
  - It is unit-testable on its own.
- The top level contains the state, owner, ptr and cnt registers, plus the output registers.

## Test plan
Use MAX_HOLD=4 unless noted; reset is held low for 2 cycles first.
- Single request: after reset, req=0001. One edge later gnt=0001, gnt_id=0, gnt_valid=1. Set req=0000: next edge gnt=0000, gnt_valid=0.
- Full contention: req=1111 held for 17 cycles.
  - gnt sequence is 0001×4, 0010×4, 0100×4, 1000×4, then 0001.
  - gnt is never zero and never multi-hot.
- No contention hold: req=0100 for 10 cycles. gnt=0100 throughout, with no drop at cnt=MAX_HOLD.
- Handoff fairness:
  - Owner 0 with req=0111; drop bit 0. Next edge gnt=0010.
  - Later, owner 2 releases into IDLE (ptr=3), then req=0101. Next edge gnt=0001, since the search runs 3→0.
- Reset mid-grant: with gnt=1000, drive reset low for one edge. After that edge, gnt=0000. Release reset with req=1001: next edge gnt=0001, because ptr has been reset to 0.
- MAX_HOLD=1, req=0011: gnt alternates 0001, 0010, 0001 every cycle.
